// File: rtl/pb_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package pb_pkg;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } pb_state_e;

    // Defaults assume a 50 MHz clock: 10 ms debounce, 500 ms first repeat, 100 ms repeat period.
    localparam int DB_CYCLES_DEF  = 500000;
    localparam int RPT_DELAY_DEF  = 25000000;
    localparam int RPT_PERIOD_DEF = 5000000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pb_conditioner_if.sv
// Push-button bundle: raw pins toward the conditioner, clean level/pulses back.
interface pb_conditioner_if #(
    parameter int N_PB = 5
);
    logic [N_PB-1:0] pb;
    logic [N_PB-1:0] pb_level;
    logic [N_PB-1:0] pb_press;
    logic [N_PB-1:0] pb_release;

    modport master (output pb, input pb_level, input pb_press, input pb_release);
    modport slave  (input pb, output pb_level, output pb_press, output pb_release);
endinterface

// File: rtl/pb_debounce_ch.sv
// One debounce channel: LOW/CHK_HI/HIGH/CHK_LO FSM over a synchronized bit.
// Auto-repeat press pulses are built only when PB_REPEAT_EN is defined.
module pb_debounce_ch
    import pb_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int RPT_DELAY  = RPT_DELAY_DEF,
    parameter int RPT_PERIOD = RPT_PERIOD_DEF,
    localparam int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic level,
    output logic press,
    output logic rel
);

    if (DB_CYCLES < 2 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_param
        $error("pb_debounce_ch: illegal timing parameters");
    end

    pb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_done;
    logic             rpt_fire;
    logic             level_d, press_d, rel_d;

    assign cnt_done = (cnt_q == CNT_W'(DB_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A sample matching the current level aborts a pending change and clears the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOW: begin
                if (s) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        level_d = (state_d == HIGH) || (state_d == CHK_LO);
        press_d = ((state_q == CHK_HI) && s && cnt_done) || rpt_fire;
        rel_d   = (state_q == CHK_LO) && !s && cnt_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            level <= level_d;
            press <= press_d;
            rel   <= rel_d;
        end
    end

`ifdef PB_REPEAT_EN
    localparam int RPT_W = $clog2(max2(RPT_DELAY, RPT_PERIOD) + 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_armed_q;
    logic             rpt_run, rpt_hit;

    // Counts only on confirmed-high samples; a pending release freezes it.
    assign rpt_run  = (state_q == HIGH) && s;
    assign rpt_hit  = rpt_armed_q ? (rpt_cnt_q == RPT_W'(RPT_PERIOD - 1))
                                  : (rpt_cnt_q == RPT_W'(RPT_DELAY - 1));
    assign rpt_fire = rpt_run && rpt_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else if (state_q == LOW || state_q == CHK_HI) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b1;
        end else if (rpt_run) begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/pb_conditioner.sv
// Push-button input conditioning: 2-FF synchronizer plus one debounce channel per pin.
// Define PB_REPEAT_EN to add auto-repeat press pulses while a button is held.
module pb_conditioner
    import pb_pkg::*;
#(
    parameter int N_PB       = 5,
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int RPT_DELAY  = RPT_DELAY_DEF,
    parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pb_conditioner_if.slave  bus
);

    logic [N_PB-1:0] sync1_q, sync2_q;
    logic [N_PB-1:0] level_w, press_w, rel_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.pb;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_PB; i++) begin : g_ch
        pb_debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .s     (sync2_q[i]),
            .level (level_w[i]),
            .press (press_w[i]),
            .rel   (rel_w[i])
        );
    end

    assign bus.pb_level   = level_w;
    assign bus.pb_press   = press_w;
    assign bus.pb_release = rel_w;

endmodule

// File: tb/tb_pb_conditioner.sv
// Scoreboard bench for pb_conditioner: run-length reference model, directed then random pins.
module tb_pb_conditioner;
    localparam int N  = 5;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef PB_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pb_conditioner_if #(.N_PB(N)) bus ();

    pb_conditioner #(
        .N_PB       (N),
        .DB_CYCLES  (DB),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference: a level flips once DB consecutive synchronized samples disagree with it.
    logic [N-1:0] m_s1, m_s2, m_lvl, m_prev;
    int           m_run[N];
    int           m_held[N];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
        end
    endtask

    task automatic step(input logic [N-1:0] p, input logic r);
        exp_t         e;
        logic [N-1:0] s;
        @(negedge clk);
        bus.pb = p;
        rst    = r;
        e      = '0;
        if (r) begin
            model_reset();
        end else begin
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = p;
            for (int i = 0; i < N; i++) begin
                if (s[i] != m_lvl[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DB) begin
                    m_lvl[i]  = s[i];
                    m_run[i]  = 0;
                    m_held[i] = 0;
                    if (s[i]) e.prs[i] = 1'b1;
                    else e.rel[i] = 1'b1;
                end else if (RPT_ON && m_lvl[i] && s[i] && m_prev[i]) begin
                    m_held[i]++;
                    if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0))
                        e.prs[i] = 1'b1;
                end
                m_prev[i] = s[i];
            end
            e.lvl = m_lvl;
        end
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [N-1:0] p, input int n);
        for (int k = 0; k < n; k++) step(p, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({bus.pb_level, bus.pb_press, bus.pb_release} !== e) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                             cyc, bus.pb_level, bus.pb_press, bus.pb_release, e.lvl, e.prs, e.rel);
                end
            end
        end
    end

    initial begin : stim
        logic [N-1:0] p;
        int           mode;
        bus.pb = '0;
        model_reset();

        // Reset with all buttons held, then re-debounce after release.
        for (int k = 0; k < 3; k++) step(5'b11111, 1'b1);
        hold(5'b11111, 12);
        hold(5'b00000, 10);

        // Clean press of pb[0].
        hold(5'b00001, 20);
        hold(5'b00000, 10);

        // Bounce on pb[2] shorter than the debounce window.
        hold(5'b00100, 1); hold(5'b00000, 1); hold(5'b00100, 2); hold(5'b00000, 10);

        // Hold then release pb[3].
        hold(5'b01000, 15);
        hold(5'b00000, 10);

        // Reset while pb[1] is mid-debounce, then held through a full debounce.
        hold(5'b00010, 4);
        step(5'b00010, 1'b1);
        hold(5'b00010, 12);
        hold(5'b00000, 10);

        // Long hold on pb[4] exercises auto-repeat when enabled.
        hold(5'b10000, 30);
        hold(5'b00000, 10);

        // Random pins in phases of fast bounce, moderate and long holds.
        p    = '0;
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0:       if ($urandom_range(0, 1) == 0)  p[i] = ~p[i];
                    1:       if ($urandom_range(0, 7) == 0)  p[i] = ~p[i];
                    default: if ($urandom_range(0, 39) == 0) p[i] = ~p[i];
                endcase
            end
            step(p, ($urandom_range(0, 499) == 0));
        end
        hold(5'b00000, 12);

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
